// File: rtl/serial_word_feeder_pkg.sv
// Shared types and sizing helpers for the serial word feeder.
// Build option: SER_PARITY_EN adds a trailing even-parity bit (PAR state).
package ser_pkg;

    // Gap counter is sized for the largest legal GAP (15).
    localparam int GAP_CNT_W = 4;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BIT  = 2'd1,
        S_GAP  = 2'd2,
        S_PAR  = 2'd3
    } ser_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BIT  = 2'd1,
        S_GAP  = 2'd2
    } ser_state_t;
`endif

    // Bit counter must reach WIDTH (all data bits emitted), hence WIDTH+1 codes.
    function automatic int bit_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_feeder_if.sv
// Word-in / bit-out bundle of the serial word feeder.
// master = upstream word source and downstream bit observer; slave = feeder.
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_valid;
    logic             ser_data;
    logic             word_done;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_valid, ser_data, word_done, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_valid, ser_data, word_done, busy
    );
endinterface

// File: rtl/serial_word_feeder_gap_timer.sv
// Idle-gap timer: loadable down-counter that flags when the gap has elapsed.
// With GAP=0 the flag is constant 1 and the counter is dead logic.
module ser_gap_timer
    import ser_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,   // a bit is being emitted; arm for the following gap
    input  logic en,     // currently inside a gap
    output logic zero
);

    localparam logic [GAP_CNT_W-1:0] LOAD_VAL =
        (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

    logic [GAP_CNT_W-1:0] cnt;

    // Count down through the gap; parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (en && (cnt != '0))
            cnt <= cnt - GAP_CNT_W'(1);
    end

    assign zero = (GAP == 0) ? 1'b1 : (cnt == '0);

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: one-deep holding register, MSB-first shifter,
// programmable idle gap after every bit. Outputs are registered so they can
// drive a pattern detector's valid/data pins directly.
// Build option: SER_PARITY_EN appends an even-parity bit after bit 0.
module serial_word_feeder
    import ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_feeder_if.slave  bus
);

    localparam int               CNT_W    = bit_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ALL_DONE = CNT_W'(WIDTH);

    ser_state_t       state, state_d;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             gap_zero;

    logic             accept;     // upstream word taken this edge
    logic             load;       // hold -> shift this edge
    logic             emit;       // data bit goes out this edge
    logic             last;       // the bit going out closes the word
    logic             word_end;   // last bit (and its gap) finished

    logic             ser_valid_q, ser_data_q, word_done_q;

`ifdef SER_PARITY_EN
    logic             par_bit;    // ^word, captured at load
    logic             par_sent;   // parity bit of current word already out
    logic             emit_par;
`endif

    // in_ready comes straight from a flop, so there is no path from in_valid.
    assign accept = bus.in_valid && !hold_full;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        emit     = 1'b0;
        last     = 1'b0;
        word_end = 1'b0;
`ifdef SER_PARITY_EN
        emit_par = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                emit = 1'b1;
`ifndef SER_PARITY_EN
                last = (bit_cnt == LAST_IDX);
`endif
                if (GAP > 0)
                    state_d = S_GAP;
                else if (bit_cnt != LAST_IDX)
                    state_d = S_BIT;
                else begin
`ifdef SER_PARITY_EN
                    state_d = S_PAR;
`else
                    word_end = 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (gap_zero) begin
                    if (bit_cnt != ALL_DONE)
                        state_d = S_BIT;
                    else begin
`ifdef SER_PARITY_EN
                        if (!par_sent)
                            state_d = S_PAR;
                        else
                            word_end = 1'b1;
`else
                        word_end = 1'b1;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
                emit_par = 1'b1;
                last     = 1'b1;
                if (GAP > 0)
                    state_d = S_GAP;
                else
                    word_end = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Chain straight into the next buffered word so spacing stays uniform.
        if (word_end) begin
            if (hold_full) begin
                load    = 1'b1;
                state_d = S_BIT;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Holding register: filled by an accept, emptied by a load (never both).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= bus.in_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Shift engine: load a word, then shift left once per emitted data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= hold_reg;
            bit_cnt   <= '0;
        end else if (emit) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

`ifdef SER_PARITY_EN
    // Parity of the loaded word and whether it has gone out yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit  <= 1'b0;
            par_sent <= 1'b0;
        end else if (load) begin
            par_bit  <= ^hold_reg;
            par_sent <= 1'b0;
        end else if (emit_par) begin
            par_sent <= 1'b1;
        end
    end
`endif

    // Registered serial outputs; data is forced low outside qualified bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_valid_q <= 1'b0;
            ser_data_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
`ifdef SER_PARITY_EN
            ser_valid_q <= emit | emit_par;
            ser_data_q  <= (emit & shift_reg[WIDTH-1]) | (emit_par & par_bit);
`else
            ser_valid_q <= emit;
            ser_data_q  <= emit & shift_reg[WIDTH-1];
`endif
            word_done_q <= last;
        end
    end

    ser_gap_timer #(
        .GAP (GAP)
    ) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SER_PARITY_EN
        .load  (emit | emit_par),
`else
        .load  (emit),
`endif
        .en    (state == S_GAP),
        .zero  (gap_zero)
    );

    assign bus.in_ready  = !hold_full;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_data  = ser_data_q;
    assign bus.word_done = word_done_q;
    assign bus.busy      = (state != S_IDLE) || hold_full;

endmodule
